// File: rtl/ctrl_suma_serie_if.sv
// Operand/result handshake bundle for ctrl_suma_serie.
// CTRL_SUMA_RESTA_EN adds the op (add/subtract) select line.
interface ctrl_suma_serie_if #(
    parameter int unsigned N_NIB = 4
);
    logic [4*N_NIB-1:0] in_a;
    logic [4*N_NIB-1:0] in_b;
    logic               cin;
    logic               in_valid;
    logic               in_ready;
    logic [4*N_NIB-1:0] sum;
    logic               cout;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
`ifdef CTRL_SUMA_RESTA_EN
    logic               op;
`endif

    modport master (
        output in_a, in_b, cin, in_valid, out_ready,
`ifdef CTRL_SUMA_RESTA_EN
        output op,
`endif
        input  in_ready, sum, cout, out_valid, busy
    );

    modport slave (
        input  in_a, in_b, cin, in_valid, out_ready,
`ifdef CTRL_SUMA_RESTA_EN
        input  op,
`endif
        output in_ready, sum, cout, out_valid, busy
    );
endinterface

// File: rtl/ctrl_suma_serie.sv
// Nibble-serial adder controller: one shared 4-bit ripple adder, one nibble per cycle.
// Optional macro CTRL_SUMA_RESTA_EN enables subtraction via the op input.
module ctrl_suma_serie #(
    parameter int unsigned N_NIB = 4
) (
    input logic            clk,
    input logic            rst,
    ctrl_suma_serie_if.slave bus
);
    localparam int unsigned W     = 4 * N_NIB;
    localparam int unsigned IDX_W = $clog2(N_NIB);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_c;

    // Shared nibble adder
    always_comb begin
        nib_a          = a_q[{idx_q, 2'b00} +: 4];
        nib_b          = b_q[{idx_q, 2'b00} +: 4];
        {nib_c, nib_s} = 5'(nib_a) + 5'(nib_b) + 5'(carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.in_a;
                    sum_d = '0;
                    idx_d = '0;
`ifdef CTRL_SUMA_RESTA_EN
                    // Subtract as A + ~B + 1; op is consumed here, so it needs no register
                    b_d     = bus.op ? ~bus.in_b : bus.in_b;
                    carry_d = bus.op ? 1'b1 : bus.cin;
`else
                    b_d     = bus.in_b;
                    carry_d = bus.cin;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[{idx_q, 2'b00} +: 4] = nib_s;
                carry_d = nib_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_NIB - 1)) begin
                    cout_d  = nib_c;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_ctrl_suma_serie.sv
// Self-checking bench for ctrl_suma_serie (N_NIB=4) against an arithmetic reference model.
module tb_ctrl_suma_serie;
    localparam int unsigned N_NIB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_suma_serie_if #(.N_NIB(N_NIB)) bus ();
    ctrl_suma_serie #(.N_NIB(N_NIB)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cout,sum} reference from plain arithmetic
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic o);
        if (o) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    task automatic set_op(input logic o);
`ifdef CTRL_SUMA_RESTA_EN
        bus.op = o;
`else
        if (o) $display("note: op ignored in add-only build");
`endif
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic o, input int unsigned hold, input bit scramble);
        logic [16:0] exp;
        int unsigned n;
        exp = model(a, b, c, o);
        check("in_ready_before", 64'(bus.in_ready), 64'd1);
        bus.in_a = a; bus.in_b = b; bus.cin = c; set_op(o);
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check("busy_calc", 64'(bus.busy), 64'd1);
        bus.in_valid = scramble;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (scramble) begin
                bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
                bus.cin = 1'($urandom); set_op(1'($urandom));
            end
        end
        check("latency", 64'(n), 64'(N_NIB));
        check("sum", 64'(bus.sum), 64'(exp[15:0]));
        check("cout", 64'(bus.cout), 64'(exp[16]));
        // Backpressure with a competing request pending
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            check("hold_sum", 64'(bus.sum), 64'(exp[15:0]));
            check("hold_cout", 64'(bus.cout), 64'(exp[16]));
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_idle_state("release");
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    endtask

    initial begin
        int unsigned seen;
        bus.in_a = '0; bus.in_b = '0; bus.cin = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; set_op(1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_state("reset");
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 3, 1'b0);
        run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1, 1'b1);

        // Reset on the second CALC cycle discards the operation
        bus.in_a = 16'hABCD; bus.in_b = 16'h1111; bus.cin = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check_idle_state("midcalc_rst");
        check("midcalc_rst_sum", 64'(bus.sum), 64'd0);
        check("midcalc_rst_cout", 64'(bus.cout), 64'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_valid || bus.busy) seen++;
        end
        check("midcalc_no_result", 64'(seen), 64'd0);
        bus.out_ready = 1'b0;

`ifdef CTRL_SUMA_RESTA_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 2, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 0, 1'b1);
`endif

        for (int i = 0; i < 30; i++) begin
            logic o;
`ifdef CTRL_SUMA_RESTA_EN
            o = 1'($urandom);
`else
            o = 1'b0;
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom), o,
                   $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
